safe_mode_sequencer: RTL

- Sequences the cores of the safe wrapper into and out of lockstep (TMR/DMR) operation, using the configuration produced by safe_wrapper_ctrl (master core, safe mode, configuration, critical section, start, end-of-routine).
- Halts the participating cores through debug requests, then runs a state-sync handshake and enables voting/lockstep.
- On routine end, parks the non-master cores and returns to idle.
- Sits between safe_wrapper_ctrl and the core debug/voter datapath.

---
 rtl/safe_mode_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/safe_mode_sequencer.sv
// safe_mode_sequencer: moves the wrapper cores into and out of lockstep
// (TMR/DMR). It halts the participating cores through debug requests, runs the
// state-sync handshake, enables voting, and parks the non-master cores on exit.
// Optional RUN-cycle counter is built only when SAFE_SEQ_PERF_CNT_EN is defined.
module safe_mode_sequencer #(
    parameter int NCORES  = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              safe_mode_i,
    input  logic [1:0]        safe_configuration_i,
    input  logic [NCORES-1:0] master_core_i,
    input  logic              critical_section_i,
    input  logic              end_sw_routine_i,
    input  logic [NCORES-1:0] debug_mode_i,
    input  logic              sync_done_i,
    output logic [NCORES-1:0] debug_req_o,
    output logic              sync_req_o,
    output logic [NCORES-1:0] lockstep_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [31:0]       run_cycles_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_SYNC,
        S_RUN,
        S_EXIT,
        S_ERROR
    } state_e;

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               start_q;
    logic               defer_q;
    logic               done_q;
    logic [NCORES-1:0]  mask_q;
    logic [NCORES-1:0]  master_q;
    logic [CNT_W-1:0]   tmo_cnt_q;

    logic               start_rise;
    logic               cfg_ok;
    logic [NCORES-1:0]  new_mask;
    logic [NCORES-1:0]  park_mask;
    logic               halt_ack;
    logic               exit_ack;
    logic               exit_req;
    logic               timed_out;

    assign start_rise = start_i & ~start_q;
    assign cfg_ok     = ~safe_configuration_i[1] & $onehot(master_core_i);
    assign park_mask  = mask_q & ~master_q;
    assign halt_ack   = (debug_mode_i & mask_q) == mask_q;
    assign exit_ack   = (debug_mode_i & park_mask) == park_mask;
    assign exit_req   = end_sw_routine_i | ~start_i;
    assign timed_out  = (tmo_cnt_q == CNT_LAST);

    // Participation mask: all cores for TMR, master plus its left neighbour for DMR.
    always_comb begin
        new_mask = '1;
        if (safe_configuration_i[0]) begin
            new_mask = master_core_i | {master_core_i[NCORES-2:0], master_core_i[NCORES-1]};
        end
    end

    // State register plus the start edge detector, mask latch, timeout counter and deferred-exit flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            defer_q   <= 1'b0;
            done_q    <= 1'b0;
            mask_q    <= '0;
            master_q  <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_i;
            done_q  <= (state_q == S_EXIT) && exit_ack;
            if (state_q == S_IDLE && state_d == S_HALT) begin
                mask_q   <= new_mask;
                master_q <= master_core_i;
            end
            if (state_d != state_q) begin
                tmo_cnt_q <= '0;
            end else if (state_q == S_HALT || state_q == S_SYNC || state_q == S_EXIT) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (state_q == S_RUN && state_d != S_RUN) begin
                defer_q <= 1'b0;
            end else if (state_q == S_RUN && exit_req && critical_section_i) begin
                defer_q <= 1'b1;
            end
        end
    end

    // Next-state logic; a handshake completing on the timeout cycle still advances.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_rise && safe_mode_i) begin
                    state_d = cfg_ok ? S_HALT : S_ERROR;
                end
            end
            S_HALT: begin
                if (halt_ack) begin
                    state_d = S_SYNC;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end
            end
            S_SYNC: begin
                if (sync_done_i) begin
                    state_d = S_RUN;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end
            end
            S_RUN: begin
                if ((exit_req || defer_q) && !critical_section_i) begin
                    state_d = S_EXIT;
                end
            end
            S_EXIT: begin
                if (exit_ack) begin
                    state_d = S_IDLE;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end
            end
            S_ERROR: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        debug_req_o   = '0;
        sync_req_o    = 1'b0;
        lockstep_en_o = '0;
        busy_o        = 1'b1;
        error_o       = 1'b0;
        case (state_q)
            S_IDLE:  busy_o = 1'b0;
            S_HALT:  debug_req_o = mask_q;
            S_SYNC: begin
                debug_req_o = mask_q;
                sync_req_o  = 1'b1;
            end
            S_RUN:   lockstep_en_o = mask_q;
            S_EXIT:  debug_req_o = park_mask;
            S_ERROR: begin
                busy_o  = 1'b0;
                error_o = 1'b1;
            end
            default: busy_o = 1'b0;
        endcase
    end

    assign done_o = done_q;

`ifdef SAFE_SEQ_PERF_CNT_EN
    logic [31:0] run_cnt_q;

    // Counts cycles spent in RUN, saturating, cleared when a new sequence enters HALT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_cnt_q <= '0;
        end else if (state_d == S_HALT && state_q != S_HALT) begin
            run_cnt_q <= '0;
        end else if (state_q == S_RUN && run_cnt_q != 32'hFFFF_FFFF) begin
            run_cnt_q <= run_cnt_q + 32'd1;
        end
    end

    assign run_cycles_o = run_cnt_q;
`else
    assign run_cycles_o = 32'd0;
`endif

endmodule
